// File: rtl/bfxp_pkg.sv
// Shared definitions for the bitfield extract-and-place unit: FSM encodings,
// default datapath width and the field-length mask helper.
package bfxp_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int MAX_XLEN     = 64;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXTRACT = 2'd1;
    localparam logic [1:0] ST_PLACE   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        EXTRACT = ST_EXTRACT,
        PLACE   = ST_PLACE,
        DONE    = ST_DONE
    } state_t;

    // Mask of len ones starting at bit 0; len=0 yields an empty mask.
    function automatic logic [MAX_XLEN-1:0] lenmask(input int unsigned len);
        lenmask = (MAX_XLEN'(1) << len) - MAX_XLEN'(1);
    endfunction

endpackage

// File: rtl/bfxp_rot.sv
// Combinational XLEN-bit rotator; dir=0 rotates right, dir=1 rotates left.
module bfxp_rot #(
    parameter  int XLEN = 32,
    localparam int LOGX = $clog2(XLEN)
) (
    input  logic [XLEN-1:0] data,
    input  logic [LOGX-1:0] amount,
    input  logic            dir,
    output logic [XLEN-1:0] result
);

    logic [LOGX-1:0] right_amount;

    // A left rotate by n is a right rotate by (XLEN - n) mod XLEN, so one shifter serves both.
    assign right_amount = dir ? (LOGX'(0) - amount) : amount;
    assign result       = XLEN'({data, data} >> right_amount);

endmodule

// File: rtl/bfxp_seq.sv
// Multi-cycle handshaked bfxp/bfxpc execution unit: extracts len bits of rs1 at
// start and places them at dest, either merged into rs2 or over a zero background.
module bfxp_seq
    import bfxp_pkg::*;
#(
    parameter  int XLEN = XLEN_DEFAULT,
    localparam int LOGX = $clog2(XLEN)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [LOGX-1:0] in_start,
    input  logic [LOGX-1:0] in_len,
    input  logic [LOGX-1:0] in_dest,
    input  logic            in_bfxpc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_rd
);

    state_t          state;
    logic [XLEN-1:0] rs1_q;
    logic [XLEN-1:0] rs2_q;
    logic [LOGX-1:0] start_q;
    logic [LOGX-1:0] len_q;
    logic [LOGX-1:0] dest_q;
    logic            bfxpc_q;
    logic [XLEN-1:0] field_q;

    logic [XLEN-1:0] rot_data;
    logic [LOGX-1:0] rot_amount;
    logic            rot_dir;
    logic [XLEN-1:0] rot_out;
    logic [XLEN-1:0] len_mask;
    logic [XLEN-1:0] src_mask;
    logic [XLEN-1:0] dst_mask;
    logic [XLEN-1:0] placed;
    logic [XLEN-1:0] merged;

    // Ready is held low during reset even though the state already reads IDLE.
    assign in_ready = (state == IDLE) && resetn;

    // The single rotator right-rotates rs1 in EXTRACT and left-rotates the field in PLACE.
    assign rot_data   = (state == PLACE) ? field_q : rs1_q;
    assign rot_amount = (state == PLACE) ? dest_q  : start_q;
    assign rot_dir    = (state == PLACE);

    bfxp_rot #(.XLEN(XLEN)) u_rot (
        .data   (rot_data),
        .amount (rot_amount),
        .dir    (rot_dir),
        .result (rot_out)
    );

    // Source bits beyond the top of rs1 must not wrap around into the field.
    assign len_mask = XLEN'(lenmask(32'(len_q)));
    assign src_mask = len_mask & ({XLEN{1'b1}} >> start_q);
    assign dst_mask = len_mask << dest_q;
    assign placed   = rot_out & dst_mask;
    assign merged   = bfxpc_q ? placed : ((rs2_q & ~dst_mask) | placed);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            rs1_q     <= '0;
            rs2_q     <= '0;
            start_q   <= '0;
            len_q     <= '0;
            dest_q    <= '0;
            bfxpc_q   <= 1'b0;
            field_q   <= '0;
            out_valid <= 1'b0;
            out_rd    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rs1_q   <= in_rs1;
                        rs2_q   <= in_rs2;
                        start_q <= in_start;
                        len_q   <= in_len;
                        dest_q  <= in_dest;
                        bfxpc_q <= in_bfxpc;
                        state   <= EXTRACT;
                    end
                end
                EXTRACT: begin
                    field_q <= rot_out & src_mask;
                    state   <= PLACE;
                end
                PLACE: begin
                    out_rd    <= merged;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bfxp_seq.sv
// Directed and randomised checks of bfxp_seq against hand-computed values and a bitwise model.
module tb_bfxp_seq;

    localparam int XLEN = 32;
    localparam int LOGX = 5;

    logic            clock;
    logic            resetn;
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [LOGX-1:0] in_start;
    logic [LOGX-1:0] in_len;
    logic [LOGX-1:0] in_dest;
    logic            in_bfxpc;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_rd;

    int tests_run    = 0;
    int tests_failed = 0;

    bfxp_seq #(.XLEN(XLEN)) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_rs1    (in_rs1),
        .in_rs2    (in_rs2),
        .in_start  (in_start),
        .in_len    (in_len),
        .in_dest   (in_dest),
        .in_bfxpc  (in_bfxpc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rd    (out_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Bit-by-bit reference: field bit i comes from rs1[start+i] and lands at rd[dest+i].
    function automatic logic [XLEN-1:0] ref_model(input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                                  input int start, input int len, input int dest,
                                                  input logic bfxpc);
        logic [XLEN-1:0] rd;
        rd = bfxpc ? '0 : rs2;
        for (int i = 0; i < len; i++) begin
            if (dest + i < XLEN)
                rd[dest + i] = (start + i < XLEN) ? rs1[start + i] : 1'b0;
        end
        return rd;
    endfunction

    task automatic applyStimulus(input string tag, input logic [XLEN-1:0] rs1, input logic [XLEN-1:0] rs2,
                                 input logic [LOGX-1:0] start, input logic [LOGX-1:0] len,
                                 input logic [LOGX-1:0] dest, input logic bfxpc,
                                 input logic [XLEN-1:0] expected);
        int waited;
        @(negedge clock);
        in_rs1   = rs1;
        in_rs2   = rs2;
        in_start = start;
        in_len   = len;
        in_dest  = dest;
        in_bfxpc = bfxpc;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!in_ready) begin
            checkOutput({tag, " accept timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clock);
        @(negedge clock);
        // Operands change after acceptance and must not disturb the result.
        in_valid = 1'b0;
        in_rs1   = $urandom;
        in_rs2   = $urandom;
        in_start = LOGX'($urandom);
        in_len   = LOGX'($urandom);
        in_dest  = LOGX'($urandom);
        in_bfxpc = ~bfxpc;
        checkOutput({tag, " busy ready"}, 32'(in_ready), 32'd0);
        checkOutput({tag, " valid early1"}, 32'(out_valid), 32'd0);
        @(negedge clock);
        checkOutput({tag, " valid early2"}, 32'(out_valid), 32'd0);
        @(negedge clock);
        checkOutput({tag, " latency"}, 32'(out_valid), 32'd1);
        waited = 0;
        while (!out_valid && waited < 10) begin
            @(negedge clock);
            waited++;
        end
        checkOutput({tag, " rd"}, out_rd, expected);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checkOutput({tag, " valid after handshake"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic [XLEN-1:0] r1;
        logic [XLEN-1:0] r2;
        logic [LOGX-1:0] st;
        logic [LOGX-1:0] ln;
        logic [LOGX-1:0] ds;
        logic            mode;

        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_rs1    = '0;
        in_rs2    = '0;
        in_start  = '0;
        in_len    = '0;
        in_dest   = '0;
        in_bfxpc  = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset out_rd", out_rd, 32'd0);
        checkOutput("reset in_ready", 32'(in_ready), 32'd0);
        resetn = 1'b1;
        @(negedge clock);
        checkOutput("idle in_ready", 32'(in_ready), 32'd1);

        applyStimulus("t1 bfxp", 32'h12345678, 32'hFFFFFFFF, 5'd8, 5'd8, 5'd0, 1'b0, 32'hFFFFFF56);
        applyStimulus("t2 bfxpc", 32'h12345678, 32'hDEADBEEF, 5'd4, 5'd12, 5'd16, 1'b1, 32'h05670000);
        applyStimulus("t3 src overflow", 32'hF0000000, 32'h00000000, 5'd28, 5'd8, 5'd0, 1'b0, 32'h0000000F);
        applyStimulus("t3 dst overflow", 32'h000000FF, 32'h12345678, 5'd0, 5'd8, 5'd28, 1'b1, 32'hF0000000);
        applyStimulus("t4 len0 bfxp", 32'h12345678, 32'hA5A5A5A5, 5'd3, 5'd0, 5'd7, 1'b0, 32'hA5A5A5A5);
        applyStimulus("t4 len0 bfxpc", 32'h12345678, 32'hA5A5A5A5, 5'd3, 5'd0, 5'd7, 1'b1, 32'h00000000);
        applyStimulus("t4 len31 bfxp", 32'hFFFFFFFF, 32'h00000000, 5'd0, 5'd31, 5'd1, 1'b0, 32'hFFFFFFFE);

        // Backpressure: second request waits until the first result is consumed.
        @(negedge clock);
        checkOutput("bp idle ready", 32'(in_ready), 32'd1);
        in_rs1 = 32'h12345678; in_rs2 = 32'hDEADBEEF;
        in_start = 5'd4; in_len = 5'd12; in_dest = 5'd16; in_bfxpc = 1'b1;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_rs1 = 32'hF0000000; in_rs2 = 32'h00000000;
        in_start = 5'd28; in_len = 5'd8; in_dest = 5'd0; in_bfxpc = 1'b0;
        @(negedge clock);
        @(negedge clock);
        checkOutput("bp first valid", 32'(out_valid), 32'd1);
        checkOutput("bp first rd", out_rd, 32'h05670000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            checkOutput("bp hold valid", 32'(out_valid), 32'd1);
            checkOutput("bp hold rd", out_rd, 32'h05670000);
            checkOutput("bp hold ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;
        checkOutput("bp released valid", 32'(out_valid), 32'd0);
        checkOutput("bp released ready", 32'(in_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        checkOutput("bp second busy", 32'(in_ready), 32'd0);
        @(negedge clock);
        @(negedge clock);
        checkOutput("bp second valid", 32'(out_valid), 32'd1);
        checkOutput("bp second rd", out_rd, 32'h0000000F);
        out_ready = 1'b1;
        @(negedge clock);
        out_ready = 1'b0;

        // Reset while in PLACE discards the request and clears the held result immediately.
        in_rs1 = 32'h12345678; in_rs2 = 32'hFFFFFFFF;
        in_start = 5'd8; in_len = 5'd8; in_dest = 5'd0; in_bfxpc = 1'b0;
        in_valid = 1'b1;
        @(posedge clock);
        @(negedge clock);
        in_valid = 1'b0;
        @(negedge clock);
        resetn = 1'b0;
        #1;
        checkOutput("mid reset valid", 32'(out_valid), 32'd0);
        checkOutput("mid reset rd", out_rd, 32'd0);
        checkOutput("mid reset ready", 32'(in_ready), 32'd0);
        @(negedge clock);
        resetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checkOutput("post reset no output", 32'(out_valid), 32'd0);
        end
        applyStimulus("t6 after reset", 32'h12345678, 32'hFFFFFFFF, 5'd8, 5'd8, 5'd0, 1'b0, 32'hFFFFFF56);

        for (int n = 0; n < 1000; n++) begin
            r1   = $urandom;
            r2   = $urandom;
            st   = LOGX'($urandom);
            ln   = LOGX'($urandom);
            ds   = LOGX'($urandom);
            mode = n[0];
            applyStimulus("random", r1, r2, st, ln, ds, mode,
                          ref_model(r1, r2, int'(st), int'(ln), int'(ds), mode));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
